// File: rtl/flight_pkg.sv
// Shared types and widths for the flight control loop scheduler.
// Contents: loop FSM state enum, counter widths, saturating increment helper.
package flight_pkg;

    localparam int unsigned LOOP_CNT_W = 16;
    localparam int unsigned MAX_LOOP_W = 16;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_IMU  = 2'd1,
        ST_PID  = 2'd2
    } loop_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [MAX_LOOP_W-1:0] sat_inc(input logic [MAX_LOOP_W-1:0] v);
        return (v == '1) ? v : v + MAX_LOOP_W'(1);
    endfunction

endpackage

// File: rtl/loop_tick_gen.sv
// Loop-rate tick generator: free-running counter 0..PERIOD-1 with
// PERIOD = BASE_FREQ / LOOP_HZ; TICK is high while the counter sits at PERIOD-1.
// Ports:
//   CLK  - system clock
//   RST  - synchronous active-high reset (counter to 0)
//   TICK - one-cycle loop tick
module loop_tick_gen #(
    parameter int unsigned BASE_FREQ = 16_000_000,
    parameter int unsigned LOOP_HZ   = 1000
) (
    input  logic CLK,
    input  logic RST,
    output logic TICK
);

    localparam int unsigned PERIOD = BASE_FREQ / LOOP_HZ;
    localparam int unsigned CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_c;

    // Terminal-count decode and wrap.
    always_comb begin
        tick_c = (cnt_q == CNT_W'(PERIOD - 1));
        cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign TICK = tick_c;

endmodule

// File: rtl/flight_loop_sched.sv
// Flight control loop scheduler: on every loop tick runs IMU read -> PID/mixer
// -> motor latch, with per-stage timeout, overrun detection and arm control.
// Optional feature macro: FLIGHT_LOOP_STATS_EN adds MAX_LOOP_CYCLES.
// Ports:
//   CLK, RST        - clock, synchronous active-high reset
//   ARM_REQ         - level arm request
//   IMU_START/DONE  - IMU read start pulse / completion pulse
//   PID_START/DONE  - PID computation start pulse / completion pulse
//   MOTOR_LATCH     - pulse loading new motor commands
//   ARMED           - motors enabled
//   OVERRUN, FAULT  - sticky status, cleared by disarming or reset
//   LOOP_CNT        - completed-loop counter (wrapping)
//   MAX_LOOP_CYCLES - longest tick-to-latch time since reset (stats build only)
module flight_loop_sched
    import flight_pkg::*;
#(
    parameter int unsigned BASE_FREQ      = 16_000_000,
    parameter int unsigned LOOP_HZ        = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 4000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ARM_REQ,
    output logic                  IMU_START,
    input  logic                  IMU_DONE,
    output logic                  PID_START,
    input  logic                  PID_DONE,
    output logic                  MOTOR_LATCH,
    output logic                  ARMED,
    output logic                  OVERRUN,
    output logic                  FAULT,
    output logic [LOOP_CNT_W-1:0] LOOP_CNT
`ifdef FLIGHT_LOOP_STATS_EN
    ,
    output logic [MAX_LOOP_W-1:0] MAX_LOOP_CYCLES
`endif
);

    localparam int unsigned STG_W = $clog2(TIMEOUT_CYCLES + 1);

    logic tick;

    loop_tick_gen #(
        .BASE_FREQ (BASE_FREQ),
        .LOOP_HZ   (LOOP_HZ)
    ) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .TICK (tick)
    );

    loop_state_e           state_q,       state_d;
    logic [STG_W-1:0]      stg_cnt_q,     stg_cnt_d;
    logic                  imu_start_q,   imu_start_d;
    logic                  pid_start_q,   pid_start_d;
    logic                  latch_q,       latch_d;
    logic                  armed_q,       armed_d;
    logic                  overrun_q,     overrun_d;
    logic                  fault_q,       fault_d;
    logic [LOOP_CNT_W-1:0] loop_cnt_q,    loop_cnt_d;
    logic                  stage_timeout;

    // Sequencing, timeout, arm and sticky-status next-state logic.
    always_comb begin
        state_d       = state_q;
        stg_cnt_d     = stg_cnt_q;
        imu_start_d   = 1'b0;
        pid_start_d   = 1'b0;
        latch_d       = 1'b0;
        armed_d       = armed_q;
        overrun_d     = overrun_q;
        fault_d       = fault_q;
        loop_cnt_d    = loop_cnt_q;
        stage_timeout = (stg_cnt_q == STG_W'(TIMEOUT_CYCLES - 1));

        // Disarming clears the sticky flags; arming only happens between loops.
        if (!ARM_REQ) begin
            armed_d   = 1'b0;
            overrun_d = 1'b0;
            fault_d   = 1'b0;
        end else if ((state_q == ST_WAIT) && !fault_q) begin
            armed_d = 1'b1;
        end

        // A tick while busy is dropped, only flagged; setting wins over clearing.
        if (tick && (state_q != ST_WAIT)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            ST_WAIT: begin
                if (tick) begin
                    state_d     = ST_IMU;
                    imu_start_d = 1'b1;
                    stg_cnt_d   = '0;
                end
            end
            ST_IMU: begin
                if (IMU_DONE) begin
                    state_d     = ST_PID;
                    pid_start_d = 1'b1;
                    stg_cnt_d   = '0;
                end else if (stage_timeout) begin
                    state_d = ST_WAIT;
                    fault_d = 1'b1;
                    armed_d = 1'b0;
                end else begin
                    stg_cnt_d = stg_cnt_q + STG_W'(1);
                end
            end
            ST_PID: begin
                if (PID_DONE) begin
                    state_d    = ST_WAIT;
                    latch_d    = 1'b1;
                    loop_cnt_d = loop_cnt_q + LOOP_CNT_W'(1);
                end else if (stage_timeout) begin
                    state_d = ST_WAIT;
                    fault_d = 1'b1;
                    armed_d = 1'b0;
                end else begin
                    stg_cnt_d = stg_cnt_q + STG_W'(1);
                end
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_WAIT;
            stg_cnt_q   <= '0;
            imu_start_q <= 1'b0;
            pid_start_q <= 1'b0;
            latch_q     <= 1'b0;
            armed_q     <= 1'b0;
            overrun_q   <= 1'b0;
            fault_q     <= 1'b0;
            loop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            stg_cnt_q   <= stg_cnt_d;
            imu_start_q <= imu_start_d;
            pid_start_q <= pid_start_d;
            latch_q     <= latch_d;
            armed_q     <= armed_d;
            overrun_q   <= overrun_d;
            fault_q     <= fault_d;
            loop_cnt_q  <= loop_cnt_d;
        end
    end

    assign IMU_START   = imu_start_q;
    assign PID_START   = pid_start_q;
    assign MOTOR_LATCH = latch_q;
    assign ARMED       = armed_q;
    assign OVERRUN     = overrun_q;
    assign FAULT       = fault_q;
    assign LOOP_CNT    = loop_cnt_q;

`ifdef FLIGHT_LOOP_STATS_EN
    logic [MAX_LOOP_W-1:0] loop_cyc_q, loop_cyc_d;
    logic [MAX_LOOP_W-1:0] max_loop_q, max_loop_d;
    logic [MAX_LOOP_W-1:0] loop_len_c;

    // loop_cyc counts cycles since the accepted tick; +1 covers the latch cycle.
    always_comb begin
        loop_cyc_d = loop_cyc_q;
        max_loop_d = max_loop_q;
        loop_len_c = sat_inc(loop_cyc_q);
        if (state_q == ST_WAIT) begin
            if (tick) begin
                loop_cyc_d = MAX_LOOP_W'(1);
            end
        end else begin
            loop_cyc_d = loop_len_c;
        end
        if ((state_q == ST_PID) && PID_DONE && (loop_len_c > max_loop_q)) begin
            max_loop_d = loop_len_c;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            loop_cyc_q <= '0;
            max_loop_q <= '0;
        end else begin
            loop_cyc_q <= loop_cyc_d;
            max_loop_q <= max_loop_d;
        end
    end

    assign MAX_LOOP_CYCLES = max_loop_q;
`endif

endmodule

// File: tb/tb_flight_loop_sched.sv
// Self-checking bench for flight_loop_sched (PERIOD=16, TIMEOUT_CYCLES=8).
// A timestamp-based reference model is compared against every output on
// every cycle; directed scenarios add hand-computed literal expectations.
module tb_flight_loop_sched;

    localparam int BASE_FREQ = 16000;
    localparam int LOOP_HZ   = 1000;
    localparam int PERIOD    = BASE_FREQ / LOOP_HZ;
    localparam int TIMEOUT   = 8;

    logic        CLK;
    logic        RST;
    logic        ARM_REQ;
    logic        IMU_START;
    logic        IMU_DONE;
    logic        PID_START;
    logic        PID_DONE;
    logic        MOTOR_LATCH;
    logic        ARMED;
    logic        OVERRUN;
    logic        FAULT;
    logic [15:0] LOOP_CNT;
`ifdef FLIGHT_LOOP_STATS_EN
    logic [15:0] MAX_LOOP_CYCLES;
`endif

    flight_loop_sched #(
        .BASE_FREQ      (BASE_FREQ),
        .LOOP_HZ        (LOOP_HZ),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .ARM_REQ     (ARM_REQ),
        .IMU_START   (IMU_START),
        .IMU_DONE    (IMU_DONE),
        .PID_START   (PID_START),
        .PID_DONE    (PID_DONE),
        .MOTOR_LATCH (MOTOR_LATCH),
        .ARMED       (ARMED),
        .OVERRUN     (OVERRUN),
        .FAULT       (FAULT),
        .LOOP_CNT    (LOOP_CNT)
`ifdef FLIGHT_LOOP_STATS_EN
        ,
        .MAX_LOOP_CYCLES (MAX_LOOP_CYCLES)
`endif
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    // Responder configuration: done pulses N cycles after the start pulse.
    int imu_dly = 3;
    int pid_dly = 4;
    bit imu_en  = 1'b1;

    int imu_times[$];
    int pid_times[$];
    int latch_times[$];

    // Reference model state.
    int          m_base     = 0;
    int          m_stage    = 0;   // 0 idle, 1 awaiting IMU, 2 awaiting PID
    int          m_entry    = 0;
    int          m_tick_cyc = 0;
    logic        m_imu_start = 1'b0;
    logic        m_pid_start = 1'b0;
    logic        m_latch     = 1'b0;
    logic        m_armed     = 1'b0;
    logic        m_ovr       = 1'b0;
    logic        m_fault     = 1'b0;
    logic [15:0] m_cnt       = '0;
    logic [15:0] m_max       = '0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Advance the model by the cycle numbered c, using the inputs seen in it.
    task automatic model_step(input int c);
        bit tick;
        bit idle;
        bit fault_was;
        bit tmo;
        int len;
        tick = (c >= m_base) && (((c - m_base) % PERIOD) == PERIOD - 1);
        m_imu_start = 1'b0;
        m_pid_start = 1'b0;
        m_latch     = 1'b0;
        if (RST) begin
            m_base  = c + 1;
            m_stage = 0;
            m_armed = 1'b0;
            m_ovr   = 1'b0;
            m_fault = 1'b0;
            m_cnt   = '0;
            m_max   = '0;
            return;
        end
        idle      = (m_stage == 0);
        fault_was = m_fault;
        tmo       = !idle && ((c - m_entry + 1) >= TIMEOUT);
        if (!ARM_REQ) begin
            m_armed = 1'b0;
            m_ovr   = 1'b0;
            m_fault = 1'b0;
        end else if (idle && !fault_was) begin
            m_armed = 1'b1;
        end
        if (tick && !idle) m_ovr = 1'b1;
        if (idle) begin
            if (tick) begin
                m_stage     = 1;
                m_entry     = c + 1;
                m_tick_cyc  = c;
                m_imu_start = 1'b1;
            end
        end else if (m_stage == 1 && IMU_DONE) begin
            m_stage     = 2;
            m_entry     = c + 1;
            m_pid_start = 1'b1;
        end else if (m_stage == 2 && PID_DONE) begin
            m_stage = 0;
            m_latch = 1'b1;
            m_cnt   = m_cnt + 16'd1;
            len     = c + 1 - m_tick_cyc;
            if (len > 65535) len = 65535;
            if (len > int'(m_max)) m_max = 16'(len);
        end else if (tmo) begin
            m_stage = 0;
            m_fault = 1'b1;
            m_armed = 1'b0;
        end
    endtask

    // Model advance and cycle numbering on the active edge.
    initial begin
        forever begin
            @(posedge CLK);
            model_step(cyc);
            cyc = cyc + 1;
        end
    end

    // Per-cycle compare against the model plus event recording.
    initial begin
        forever begin
            @(negedge CLK);
            if (chk_en) begin
                check("imu_start",   {15'd0, IMU_START},   {15'd0, m_imu_start});
                check("pid_start",   {15'd0, PID_START},   {15'd0, m_pid_start});
                check("motor_latch", {15'd0, MOTOR_LATCH}, {15'd0, m_latch});
                check("armed",       {15'd0, ARMED},       {15'd0, m_armed});
                check("overrun",     {15'd0, OVERRUN},     {15'd0, m_ovr});
                check("fault",       {15'd0, FAULT},       {15'd0, m_fault});
                check("loop_cnt",    LOOP_CNT,             m_cnt);
`ifdef FLIGHT_LOOP_STATS_EN
                check("max_loop",    MAX_LOOP_CYCLES,      m_max);
`endif
                if (IMU_START === 1'b1)   imu_times.push_back(cyc);
                if (PID_START === 1'b1)   pid_times.push_back(cyc);
                if (MOTOR_LATCH === 1'b1) latch_times.push_back(cyc);
            end
        end
    end

    // Done-pulse responder driven on the falling edge.
    initial begin
        int imu_cd;
        int pid_cd;
        imu_cd   = 0;
        pid_cd   = 0;
        IMU_DONE = 1'b0;
        PID_DONE = 1'b0;
        forever begin
            @(negedge CLK);
            IMU_DONE = 1'b0;
            PID_DONE = 1'b0;
            if (imu_cd > 0) begin
                imu_cd--;
                if (imu_cd == 0) IMU_DONE = 1'b1;
            end
            if (pid_cd > 0) begin
                pid_cd--;
                if (pid_cd == 0) PID_DONE = 1'b1;
            end
            if (IMU_START === 1'b1 && imu_en) imu_cd = imu_dly;
            if (PID_START === 1'b1) pid_cd = pid_dly;
        end
    end

    initial begin
        repeat (3000) @(posedge CLK);
        $display("FAIL watchdog: cycle %0d reached, required finish before 3000", cyc);
        $fatal(1, "watchdog expired");
    end

    function automatic int qsize(input int which);
        case (which)
            0:       return imu_times.size();
            1:       return pid_times.size();
            default: return latch_times.size();
        endcase
    endfunction

    task automatic wait_count(input string what, input int which, input int target, input int budget);
        int k;
        k = 0;
        while (qsize(which) < target && k < budget) begin
            @(negedge CLK);
            k++;
        end
        n_cmp++;
        if (qsize(which) < target) begin
            n_bad++;
            $display("FAIL %s: got %0d events, expected %0d within %0d cycles", what, qsize(which), target, budget);
        end
    endtask

    task automatic goto_cyc(input int target);
        while (cyc < target) @(negedge CLK);
    endtask

    initial begin
        int base;
        int s;
        int p;
        int nl;
        RST     = 1'b1;
        ARM_REQ = 1'b0;
        repeat (3) @(negedge CLK);
        chk_en = 1'b1;

        // Reset state.
        check("rst_imu_start", {15'd0, IMU_START},   16'd0);
        check("rst_pid_start", {15'd0, PID_START},   16'd0);
        check("rst_latch",     {15'd0, MOTOR_LATCH}, 16'd0);
        check("rst_armed",     {15'd0, ARMED},       16'd0);
        check("rst_overrun",   {15'd0, OVERRUN},     16'd0);
        check("rst_fault",     {15'd0, FAULT},       16'd0);
        check("rst_loop_cnt",  LOOP_CNT,             16'd0);

        // Five normal loops: IMU done +3, PID done +4.
        RST     = 1'b0;
        ARM_REQ = 1'b1;
        base    = cyc;
        wait_count("five_loops", 2, 5, 120);
        goto_cyc(latch_times[4] + 1);
        check("first_imu_start", 16'(imu_times[0] - base), 16'd16);
        for (int i = 0; i < 4; i++) begin
            check("imu_period", 16'(imu_times[i + 1] - imu_times[i]), 16'd16);
        end
        check("start_to_latch", 16'(latch_times[0] - imu_times[0]), 16'd9);
        check("loops_latched",  16'(latch_times.size()), 16'd5);
        check("loop_cnt_5",     LOOP_CNT, 16'd5);
        check("armed_running",  {15'd0, ARMED}, 16'd1);
`ifdef FLIGHT_LOOP_STATS_EN
        check("max_loop_10", MAX_LOOP_CYCLES, 16'd10);
`endif

        // Long loop: PID_DONE coincides with the next tick -> overrun, 32-cycle gap.
        imu_dly = 7;
        pid_dly = 7;
        wait_count("long_loop", 2, 6, 60);
        imu_dly = 3;
        pid_dly = 4;
        wait_count("after_overrun", 0, 7, 60);
        check("overrun_gap", 16'(imu_times[6] - imu_times[5]), 16'd32);
        check("overrun_set", {15'd0, OVERRUN}, 16'd1);
        check("no_fault",    {15'd0, FAULT},   16'd0);
        check("loop_cnt_6",  LOOP_CNT,         16'd6);
`ifdef FLIGHT_LOOP_STATS_EN
        check("max_loop_17", MAX_LOOP_CYCLES, 16'd17);
`endif

        // Disarm to clear overrun, re-arm.
        wait_count("loop_7", 2, 7, 60);
        ARM_REQ = 1'b0;
        @(negedge CLK);
        ARM_REQ = 1'b1;
        @(negedge CLK);
        check("overrun_cleared", {15'd0, OVERRUN}, 16'd0);
        check("rearmed",         {15'd0, ARMED},   16'd1);

        // IMU timeout: fault exactly 8 cycles after IMU entry, no latch.
        imu_en = 1'b0;
        nl = latch_times.size();
        wait_count("timeout_start", 0, 8, 40);
        s = imu_times[7];
        goto_cyc(s + 7);
        check("fault_pre_timeout", {15'd0, FAULT}, 16'd0);
        goto_cyc(s + 8);
        check("fault_on_timeout",  {15'd0, FAULT}, 16'd1);
        check("disarm_on_timeout", {15'd0, ARMED}, 16'd0);
        imu_en  = 1'b1;
        ARM_REQ = 1'b0;
        goto_cyc(s + 9);
        ARM_REQ = 1'b1;
        goto_cyc(s + 10);
        check("fault_cleared",   {15'd0, FAULT}, 16'd0);
        check("armed_again",     {15'd0, ARMED}, 16'd1);
        check("no_timeout_latch", 16'(latch_times.size()), 16'(nl));

        // Reset two cycles into PID; the late PID_DONE must be ignored.
        wait_count("pid_for_reset", 1, 8, 40);
        p = pid_times[7];
        goto_cyc(p + 2);
        RST = 1'b1;
        goto_cyc(p + 3);
        RST = 1'b0;
        nl = latch_times.size();
        check("mid_rst_imu_start", {15'd0, IMU_START},   16'd0);
        check("mid_rst_pid_start", {15'd0, PID_START},   16'd0);
        check("mid_rst_latch",     {15'd0, MOTOR_LATCH}, 16'd0);
        check("mid_rst_armed",     {15'd0, ARMED},       16'd0);
        check("mid_rst_overrun",   {15'd0, OVERRUN},     16'd0);
        check("mid_rst_fault",     {15'd0, FAULT},       16'd0);
        check("mid_rst_loop_cnt",  LOOP_CNT,             16'd0);
        goto_cyc(p + 8);
        check("late_done_ignored", 16'(latch_times.size()), 16'(nl));
        check("loop_cnt_still_0",  LOOP_CNT, 16'd0);

        // Preload counter to 0xFFFF, one loop wraps it to 0.
        #1;
        force dut.loop_cnt_q = 16'hFFFF;
        m_cnt = 16'hFFFF;
        @(negedge CLK);
        #1;
        release dut.loop_cnt_q;
        wait_count("wrap_loop", 2, nl + 1, 60);
        goto_cyc(latch_times[nl] + 1);
        check("loop_cnt_wrap", LOOP_CNT, 16'd0);
`ifdef FLIGHT_LOOP_STATS_EN
        check("max_after_rst", MAX_LOOP_CYCLES, 16'd10);
`endif

        repeat (4) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
